// File: rtl/des_key_sched.sv
// DES key-schedule generator: PC-1 on load, then per-round C/D half rotations emitted over valid/ready.
// Optional build macro DES_KEY_PARITY_EN enables per-byte odd-parity checking of accepted keys.
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        key_load,
  input  logic        decrypt,
  output logic        key_ready,
  input  logic        key_abort,
  output logic [55:0] cn_dn,
  output logic [3:0]  round_idx,
  output logic        cn_dn_valid,
  input  logic        cn_dn_ready,
  output logic        sched_done,
  output logic        key_parity_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic   decrypt_q;
  logic   accept;
  logic   parity_ok;
  logic   load_go;
  logic   advance;
  logic   done_d;
  logic   two_step;
  logic [55:0] cd0;
  logic [55:0] next_cd;

  // Key bit n (FIPS numbering, 1 = MSB) lives at key_in[64-n].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
            k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
            k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
            k[4],  k[12], k[20], k[28],
            k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
            k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
            k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
            k[36], k[44], k[52], k[60]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
  function automatic logic shift_is_two(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [27:0] half_rot(input logic [27:0] h, input logic left,
                                           input logic two);
    logic [27:0] res;
    if (left)
      res = two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    else
      res = two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    return res;
  endfunction

  function automatic logic [55:0] cd_rot(input logic [55:0] cd, input logic left,
                                         input logic two);
    return {half_rot(cd[55:28], left, two), half_rot(cd[27:0], left, two)};
  endfunction

  function automatic logic odd_parity(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++)
      if (!(^k[8*b +: 8])) ok = 1'b0;
    return ok;
  endfunction

  assign cd0 = pc1(key_in);

  // Encrypt walks forward through s[], decrypt walks the same table backwards.
  assign two_step = decrypt_q ? shift_is_two(5'd16 - {1'b0, round_idx})
                              : shift_is_two({1'b0, round_idx} + 5'd2);
  assign next_cd  = cd_rot(cn_dn, !decrypt_q, two_step);

  assign accept = !key_abort && (state_q == IDLE) && key_load;

`ifdef DES_KEY_PARITY_EN
  assign parity_ok = odd_parity(key_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      key_parity_err <= 1'b0;
    else if (accept)
      key_parity_err <= !parity_ok;
  end
`else
  assign parity_ok      = 1'b1;
  assign key_parity_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load_go = 1'b0;
    advance = 1'b0;
    done_d  = 1'b0;
    if (key_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && parity_ok) begin
            load_go = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (cn_dn_ready) begin
            if (round_idx == 4'd15) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  assign key_ready   = (state_q == IDLE);
  assign cn_dn_valid = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cn_dn      <= '0;
      round_idx  <= '0;
      decrypt_q  <= 1'b0;
      sched_done <= 1'b0;
    end else begin
      sched_done <= done_d;
      if (load_go) begin
        cn_dn     <= decrypt ? cd0 : cd_rot(cd0, 1'b1, 1'b0);
        round_idx <= '0;
        decrypt_q <= decrypt;
      end else if (advance) begin
        cn_dn     <= next_cd;
        round_idx <= round_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched against a table-driven DES key-schedule model.
module tb_des_key_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_load = 1'b0;
  logic        decrypt = 1'b0;
  logic        key_abort = 1'b0;
  logic        cn_dn_ready = 1'b0;
  logic        key_ready;
  logic [55:0] cn_dn;
  logic [3:0]  round_idx;
  logic        cn_dn_valid;
  logic        sched_done;
  logic        key_parity_err;

  int vectors = 0;
  int miscompares = 0;

  logic [55:0] got_cd [16];
  logic [3:0]  got_idx [16];

  int s_tbl [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int pc1_tbl [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                       10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                       63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                       14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD  = 64'h133457799BBCDFF0;

  des_key_sched dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .decrypt(decrypt), .key_ready(key_ready), .key_abort(key_abort),
    .cn_dn(cn_dn), .round_idx(round_idx), .cn_dn_valid(cn_dn_valid),
    .cn_dn_ready(cn_dn_ready), .sched_done(sched_done),
    .key_parity_err(key_parity_err)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] model_pc1(input logic [63:0] k);
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - pc1_tbl[i]];
    return cd;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] h, input int n);
    int m;
    m = n % 28;
    if (m == 0) return h;
    return (h << m) | (h >> (28 - m));
  endfunction

  // Round r (1..16) value; decrypt round r is encrypt round 17-r.
  function automatic logic [55:0] model_round(input logic [63:0] k, input logic d, input int r);
    logic [55:0] c0;
    int er, tot;
    c0 = model_pc1(k);
    er = d ? 17 - r : r;
    tot = 0;
    for (int i = 0; i < er; i++) tot += s_tbl[i];
    return {rotl28(c0[55:28], tot), rotl28(c0[27:0], tot)};
  endfunction

  function automatic logic [63:0] make_odd(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+1 +: 7];
    return r;
  endfunction

  task automatic load(input logic [63:0] k, input logic d);
    key_in = k;
    decrypt = d;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Drives cn_dn_ready and captures accepted beats; mode 0 ready high, 1 stall at round 4
  // then random, 2 random, 3 ready high with key_load hammered during RUN.
  task automatic collect(input int mode, output int nb, output int unstable, output int vcyc);
    logic [55:0] prev_cd;
    logic [3:0]  prev_idx;
    logic        stalled, rdy;
    int          stall_cnt, guard;
    nb = 0; unstable = 0; vcyc = 0; stalled = 1'b0; stall_cnt = 0; guard = 0;
    prev_cd = '0; prev_idx = '0;
    while (nb < 16 && guard < 400) begin
      guard++;
      if (stalled && (!cn_dn_valid || cn_dn !== prev_cd || round_idx !== prev_idx)) unstable++;
      case (mode)
        1: begin
          if (round_idx == 4'd4 && stall_cnt < 3) begin rdy = 1'b0; stall_cnt++; end
          else if (stall_cnt >= 3) rdy = 1'($urandom_range(0, 1));
          else rdy = 1'b1;
        end
        2: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      if (mode == 3) begin
        key_load = 1'b1;
        key_in = {$urandom, $urandom};
        decrypt = ~decrypt;
      end
      cn_dn_ready = rdy;
      if (cn_dn_valid) vcyc++;
      if (cn_dn_valid && rdy) begin
        got_cd[nb] = cn_dn;
        got_idx[nb] = round_idx;
        nb++;
      end
      stalled = cn_dn_valid && !rdy;
      prev_cd = cn_dn;
      prev_idx = round_idx;
      @(negedge clk);
    end
    cn_dn_ready = 1'b0;
    key_load = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({key_ready, cn_dn_valid, cn_dn, round_idx, sched_done, key_parity_err} !==
        {1'b1, 1'b0, 56'h0, 4'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got ready=%b valid=%b cd=%h idx=%0d done=%b err=%b, want 1 0 0 0 0 0",
               key_ready, cn_dn_valid, cn_dn, round_idx, sched_done, key_parity_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_encrypt_kv;
    int nb, unst, vc;
    load(KEY_GOOD, 1'b0);
    collect(0, nb, unst, vc);
    vectors++;
    if (nb !== 16 || vc !== 16) begin
      miscompares++;
      $display("FAIL enc_count: beats=%0d valid_cycles=%0d, want 16 16", nb, vc);
    end
    vectors++;
    if (got_cd[0] !== 56'hE19955FAACCF1E) begin
      miscompares++;
      $display("FAIL enc_round1: got %h want E19955FAACCF1E", got_cd[0]);
    end
    vectors++;
    if (got_cd[15] !== 56'hF0CCAAF556678F) begin
      miscompares++;
      $display("FAIL enc_round16: got %h want F0CCAAF556678F", got_cd[15]);
    end
    for (int r = 0; r < 16; r++) begin
      vectors++;
      if (got_cd[r] !== model_round(KEY_GOOD, 1'b0, r + 1) || got_idx[r] !== 4'(r)) begin
        miscompares++;
        $display("FAIL enc_beat%0d: got %h idx %0d want %h idx %0d", r, got_cd[r], got_idx[r],
                 model_round(KEY_GOOD, 1'b0, r + 1), r);
      end
    end
    vectors++;
    if (sched_done !== 1'b1 || key_ready !== 1'b1 || cn_dn_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enc_done: done=%b ready=%b valid=%b want 1 1 0", sched_done, key_ready, cn_dn_valid);
    end
    @(negedge clk);
    vectors++;
    if (sched_done !== 1'b0) begin
      miscompares++;
      $display("FAIL enc_done_pulse: done=%b want 0", sched_done);
    end
  endtask

  task automatic test_decrypt;
    int nb, unst, vc;
    load(KEY_GOOD, 1'b1);
    collect(0, nb, unst, vc);
    vectors++;
    if (got_cd[0] !== 56'hF0CCAAF556678F || got_cd[15] !== 56'hE19955FAACCF1E) begin
      miscompares++;
      $display("FAIL dec_ends: got %h / %h want F0CCAAF556678F / E19955FAACCF1E", got_cd[0], got_cd[15]);
    end
    for (int r = 0; r < 16; r++) begin
      vectors++;
      if (got_cd[r] !== model_round(KEY_GOOD, 1'b0, 16 - r) || got_idx[r] !== 4'(r)) begin
        miscompares++;
        $display("FAIL dec_beat%0d: got %h idx %0d want %h", r, got_cd[r], got_idx[r],
                 model_round(KEY_GOOD, 1'b0, 16 - r));
      end
    end
    vectors++;
    if (sched_done !== 1'b1) begin
      miscompares++;
      $display("FAIL dec_done: done=%b want 1", sched_done);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int nb, unst, vc;
    load(KEY_GOOD, 1'b0);
    collect(1, nb, unst, vc);
    vectors++;
    if (unst !== 0 || vc < 19) begin
      miscompares++;
      $display("FAIL bp_stall: unstable=%0d valid_cycles=%0d want 0 and >=19", unst, vc);
    end
    for (int r = 0; r < 16; r++) begin
      vectors++;
      if (got_cd[r] !== model_round(KEY_GOOD, 1'b0, r + 1) || got_idx[r] !== 4'(r)) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got %h idx %0d want %h", r, got_cd[r], got_idx[r],
                 model_round(KEY_GOOD, 1'b0, r + 1));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int nb, unst, vc;
    logic [63:0] k;
    logic d;
    for (int t = 0; t < 6; t++) begin
      k = make_odd({$urandom, $urandom});
      d = 1'($urandom_range(0, 1));
      load(k, d);
      collect(2, nb, unst, vc);
      vectors++;
      if (unst !== 0 || nb !== 16 || sched_done !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd%0d_flow: unstable=%0d beats=%0d done=%b want 0 16 1", t, unst, nb, sched_done);
      end
      for (int r = 0; r < 16; r++) begin
        vectors++;
        if (got_cd[r] !== model_round(k, d, r + 1) || got_idx[r] !== 4'(r)) begin
          miscompares++;
          $display("FAIL rnd%0d_beat%0d: got %h idx %0d want %h", t, r, got_cd[r], got_idx[r],
                   model_round(k, d, r + 1));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort;
    int nb, unst, vc, guard;
    // Abort at round_idx 7 while ready is high: abort beats the transfer.
    load(KEY_GOOD, 1'b0);
    cn_dn_ready = 1'b1;
    guard = 0;
    while (round_idx != 4'd7 && guard < 40) begin @(negedge clk); guard++; end
    key_abort = 1'b1;
    @(negedge clk);
    key_abort = 1'b0;
    cn_dn_ready = 1'b0;
    vectors++;
    if (key_ready !== 1'b1 || cn_dn_valid !== 1'b0 || sched_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort7: ready=%b valid=%b done=%b want 1 0 0", key_ready, cn_dn_valid, sched_done);
    end
    @(negedge clk);
    vectors++;
    if (sched_done !== 1'b0 || cn_dn_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort7_after: done=%b valid=%b want 0 0", sched_done, cn_dn_valid);
    end
    // Abort coincident with the round-16 transfer: no sched_done.
    load(KEY_GOOD, 1'b1);
    cn_dn_ready = 1'b1;
    guard = 0;
    while (round_idx != 4'd15 && guard < 40) begin @(negedge clk); guard++; end
    key_abort = 1'b1;
    @(negedge clk);
    key_abort = 1'b0;
    cn_dn_ready = 1'b0;
    vectors++;
    if (sched_done !== 1'b0 || key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort15: done=%b ready=%b want 0 1", sched_done, key_ready);
    end
    // Abort together with a load in IDLE: key must not be taken.
    key_abort = 1'b1;
    load(KEY_GOOD, 1'b0);
    key_abort = 1'b0;
    vectors++;
    if (cn_dn_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_load: valid=%b want 0", cn_dn_valid);
    end
    // Loads while running are ignored.
    load(KEY_GOOD, 1'b0);
    collect(3, nb, unst, vc);
    for (int r = 0; r < 16; r++) begin
      vectors++;
      if (got_cd[r] !== model_round(KEY_GOOD, 1'b0, r + 1)) begin
        miscompares++;
        $display("FAIL runload_beat%0d: got %h want %h", r, got_cd[r], model_round(KEY_GOOD, 1'b0, r + 1));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int nb, unst, vc;
    logic [63:0] k2;
    k2 = make_odd({$urandom, $urandom});
    load(KEY_GOOD, 1'b0);
    collect(0, nb, unst, vc);
    vectors++;
    if (sched_done !== 1'b1 || key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: done=%b ready=%b want 1 1", sched_done, key_ready);
    end
    load(k2, 1'b0);
    vectors++;
    if (cn_dn_valid !== 1'b1 || round_idx !== 4'd0 || cn_dn !== model_round(k2, 1'b0, 1)) begin
      miscompares++;
      $display("FAIL b2b_first: valid=%b idx=%0d cd=%h want 1 0 %h", cn_dn_valid, round_idx, cn_dn,
               model_round(k2, 1'b0, 1));
    end
    cn_dn_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({key_ready, cn_dn_valid, cn_dn, round_idx, sched_done, key_parity_err} !==
        {1'b1, 1'b0, 56'h0, 4'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_rst: ready=%b valid=%b cd=%h idx=%0d done=%b err=%b want 1 0 0 0 0 0",
               key_ready, cn_dn_valid, cn_dn, round_idx, sched_done, key_parity_err);
    end
    cn_dn_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_parity;
    int nb, unst, vc, seen;
`ifdef DES_KEY_PARITY_EN
    load(KEY_BAD, 1'b0);
    seen = 0;
    cn_dn_ready = 1'b1;
    repeat (20) begin
      if (cn_dn_valid || sched_done) seen++;
      @(negedge clk);
    end
    cn_dn_ready = 1'b0;
    vectors++;
    if (key_parity_err !== 1'b1 || seen !== 0 || key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_bad: err=%b beats=%0d ready=%b want 1 0 1", key_parity_err, seen, key_ready);
    end
    load(KEY_GOOD, 1'b0);
    vectors++;
    if (key_parity_err !== 1'b0 || cn_dn_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_clear: err=%b valid=%b want 0 1", key_parity_err, cn_dn_valid);
    end
    collect(0, nb, unst, vc);
    vectors++;
    if (nb !== 16 || got_cd[15] !== 56'hF0CCAAF556678F || sched_done !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_run: beats=%0d last=%h done=%b want 16 F0CCAAF556678F 1", nb, got_cd[15], sched_done);
    end
`else
    seen = 0;
    load(KEY_BAD, 1'b0);
    collect(0, nb, unst, vc);
    for (int r = 0; r < 16; r++)
      if (got_cd[r] !== model_round(KEY_BAD, 1'b0, r + 1)) seen++;
    vectors++;
    if (nb !== 16 || seen !== 0 || sched_done !== 1'b1 || key_parity_err !== 1'b0) begin
      miscompares++;
      $display("FAIL noparity_run: beats=%0d bad_beats=%0d done=%b err=%b want 16 0 1 0",
               nb, seen, sched_done, key_parity_err);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_encrypt_kv;
    test_decrypt;
    test_backpressure;
    test_random;
    test_abort;
    test_back_to_back;
    test_parity;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
